// File: rtl/module_isa_defs_pkg.sv
// ISA constants shared by the fetch unit and the control unit decoder.
// Opcode occupies the top OPCODE bits of each instruction word.
package module_isa_defs;

  localparam int unsigned ISA_OPCODE_W = 3;
  localparam int unsigned ISA_INSTR_W  = 16;
  localparam int unsigned ISA_ADDR_W   = 8;
  localparam int unsigned ISA_OP_MSB   = ISA_INSTR_W - 1;

  localparam logic [ISA_OPCODE_W-1:0] OP_ADD  = 3'b000;
  localparam logic [ISA_OPCODE_W-1:0] OP_MOVI = 3'b001;
  localparam logic [ISA_OPCODE_W-1:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    FETCH_IDLE   = 2'd0,
    FETCH_RUN    = 2'd1,
    FETCH_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/module_instr_fetch_queue.sv
// Two-entry FIFO of {addr, word} between instruction memory return and decode.
// Head outputs read as zero while empty; flush wins over push and pop.
module module_fetch_queue #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [ADDR_W-1:0]  push_addr,
  input  logic [INSTR_W-1:0] push_word,
  input  logic               pop,
  input  logic               flush,
  output logic [1:0]         count,
  output logic [ADDR_W-1:0]  head_addr,
  output logic [INSTR_W-1:0] head_word
);

  logic [ADDR_W-1:0]  addr_q [2];
  logic [INSTR_W-1:0] word_q [2];
  logic               rd_ptr;
  logic               wr_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        addr_q[i] <= '0;
        word_q[i] <= '0;
      end
    end else if (flush) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        addr_q[wr_ptr] <= push_addr;
        word_q[wr_ptr] <= push_word;
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head_addr = (count != 2'd0) ? addr_q[rd_ptr] : '0;
  assign head_word = (count != 2'd0) ? word_q[rd_ptr] : '0;

endmodule

// File: rtl/module_instr_fetch.sv
// Instruction fetch/issue: walks pc through a 1-cycle-latency instruction memory,
// queues returned words and hands them to decode over valid/ready.
module module_instr_fetch
  import module_isa_defs::*;
#(
  parameter int unsigned        OPCODE  = ISA_OPCODE_W,
  parameter int unsigned        INSTR_W = ISA_INSTR_W,
  parameter int unsigned        ADDR_W  = ISA_ADDR_W,
  parameter logic [OPCODE-1:0]  HALT_OP = OPCODE'(OP_HALT)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  start_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_rd_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_word,
  output logic [OPCODE-1:0]  opcode,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               halted
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  iss_addr_q, iss_addr_d;
  logic               inflight_q, inflight_d;
  logic               drop_q, drop_d;
  logic               halt_seen_q, halt_seen_d;

  logic [1:0]         count;
  logic [ADDR_W-1:0]  head_addr;
  logic [INSTR_W-1:0] head_word;
  logic               pop;
  logic               push;
  logic               push_is_halt;
  logic               in_run;
  logic               redir;
  logic               issue;
  logic [2:0]         occupancy;

  assign in_run       = (state_q == FETCH_RUN);
  assign redir        = in_run & redirect_valid;
  assign instr_valid  = (count != 2'd0);
  assign pop          = instr_valid & instr_ready;
  // Slots already claimed after this cycle's pop: queued words plus the pending return.
  assign occupancy    = 3'(count) + 3'(inflight_q) - 3'(pop);
  assign issue        = in_run & ~redirect_valid & ~halt_seen_q & (occupancy < 3'd2);
  assign push         = in_run & inflight_q & ~drop_q & ~halt_seen_q;
  assign push_is_halt = (imem_rdata[INSTR_W-1 -: OPCODE] == HALT_OP);

  module_fetch_queue #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (iss_addr_q),
    .push_word (imem_rdata),
    .pop       (pop),
    .flush     (redir),
    .count     (count),
    .head_addr (head_addr),
    .head_word (head_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH_IDLE;
      pc_q        <= '0;
      iss_addr_q  <= '0;
      inflight_q  <= 1'b0;
      drop_q      <= 1'b0;
      halt_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      iss_addr_q  <= iss_addr_d;
      inflight_q  <= inflight_d;
      drop_q      <= drop_d;
      halt_seen_q <= halt_seen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    iss_addr_d  = iss_addr_q;
    inflight_d  = 1'b0;
    drop_d      = 1'b0;
    halt_seen_d = halt_seen_q;
    case (state_q)
      FETCH_IDLE, FETCH_HALTED: begin
        if (start) begin
          state_d     = FETCH_RUN;
          pc_d        = start_pc;
          halt_seen_d = 1'b0;
        end
      end
      FETCH_RUN: begin
        if (redirect_valid) begin
          pc_d        = redirect_pc;
          drop_d      = inflight_q;
          halt_seen_d = 1'b0;
        end else begin
          if (issue) begin
            pc_d       = pc_q + ADDR_W'(1);
            inflight_d = 1'b1;
            iss_addr_d = pc_q;
          end
          if (push && push_is_halt) begin
            halt_seen_d = 1'b1;
          end
          // Anything returning alongside the last pop is discarded, so an empty queue means done.
          if (halt_seen_q && ((count - 2'(pop)) == 2'd0)) begin
            state_d = FETCH_HALTED;
          end
        end
      end
      default: state_d = FETCH_IDLE;
    endcase
  end

  assign imem_rd_en = issue;
  assign imem_addr  = pc_q;
  assign instr_word = head_word;
  assign instr_pc   = head_addr;
  assign opcode     = head_word[INSTR_W-1 -: OPCODE];
  assign halted     = (state_q == FETCH_HALTED);

endmodule

// File: tb/tb_module_instr_fetch.sv
// Bench for module_instr_fetch: memory model, delivered-stream reference model
// and directed scenarios with literal expectations.
module tb_module_instr_fetch;
  import module_isa_defs::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  start_pc = 8'h00;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = 8'h00;
  logic        imem_rd_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata = 16'h0000;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [15:0] instr_word;
  logic [2:0]  opcode;
  logic [7:0]  instr_pc;
  logic        halted;

  module_instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .start_pc       (start_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_word     (instr_word),
    .opcode         (opcode),
    .instr_pc       (instr_pc),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Instruction memory: synchronous read, garbage on cycles without a read.
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (imem_rd_en) imem_rdata <= mem[imem_addr];
    else            imem_rdata <= 16'($urandom);
  end

  // Ready driver: level from the main sequence, or the 1,0,0,1 pattern.
  int   ready_mode  = 0;
  logic ready_level = 1'b1;
  int   ph = 0;
  always @(posedge clk) begin
    #1;
    if (ready_mode == 1) begin
      instr_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
      ph++;
    end else begin
      instr_ready = ready_level;
    end
  end

  // Reference model: the head must always be the next address of the program stream.
  typedef enum {M_IDLE, M_RUN, M_HALTED} mst_e;
  mst_e        mst = M_IDLE;
  logic [7:0]  exp_pc = 8'h00;
  logic [7:0]  iss_exp = 8'h00;
  bit          armed = 1'b0;
  bit          stall = 1'b0;
  bit          halt_iss = 1'b0;
  int          after_halt = 0;
  logic [15:0] st_word;
  logic [7:0]  st_pc;
  logic [7:0]  acc_log [$];

  always @(negedge clk) begin
    if (armed) begin
      check("halted", 32'(halted), 32'(mst == M_HALTED));
      if (mst != M_RUN) begin
        check("valid_outside_run", 32'(instr_valid), 32'd0);
        check("rd_en_outside_run", 32'(imem_rd_en), 32'd0);
      end
      if (!instr_valid) begin
        check("empty_word", 32'(instr_word), 32'd0);
        check("empty_opcode", 32'(opcode), 32'd0);
        check("empty_pc", 32'(instr_pc), 32'd0);
      end else begin
        check("head_pc", 32'(instr_pc), 32'(exp_pc));
        check("head_word", 32'(instr_word), 32'(mem[exp_pc]));
        check("head_opcode", 32'(opcode), 32'(mem[exp_pc][15:13]));
      end
      if (stall) begin
        check("stall_valid", 32'(instr_valid), 32'd1);
        check("stall_word", 32'(instr_word), 32'(st_word));
        check("stall_pc", 32'(instr_pc), 32'(st_pc));
      end
      if (mst == M_RUN && imem_rd_en) begin
        check("issue_addr", 32'(imem_addr), 32'(iss_exp));
        check("issue_in_redirect", 32'(redirect_valid), 32'd0);
        if (halt_iss) begin
          after_halt++;
          check("issue_past_halt", 32'(after_halt <= 1), 32'd1);
        end
        if (mem[imem_addr][15:13] == OP_HALT) halt_iss = 1'b1;
        iss_exp++;
      end
    end
    stall = 1'b0;
    if (rst) begin
      armed = 1'b1;
      mst   = M_IDLE;
    end else if (armed) begin
      case (mst)
        M_IDLE, M_HALTED: begin
          if (start) begin
            mst        = M_RUN;
            exp_pc     = start_pc;
            iss_exp    = start_pc;
            halt_iss   = 1'b0;
            after_halt = 0;
          end
        end
        default: begin
          bit hp;
          hp = 1'b0;
          if (instr_valid && instr_ready) begin
            acc_log.push_back(instr_pc);
            hp = (mem[exp_pc][15:13] == OP_HALT);
            exp_pc++;
          end else if (instr_valid) begin
            stall   = !redirect_valid;
            st_word = instr_word;
            st_pc   = instr_pc;
          end
          if (redirect_valid) begin
            exp_pc     = redirect_pc;
            iss_exp    = redirect_pc;
            halt_iss   = 1'b0;
            after_halt = 0;
          end else if (hp) begin
            mst = M_HALTED;
          end
        end
      endcase
    end
  end

  task automatic run_start(input logic [7:0] pc, output int lat);
    @(posedge clk); #1;
    start = 1'b1;
    start_pc = pc;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!instr_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic wait_halt(input string name, input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(halted), 32'd1);
  endtask

  task automatic check_log(input string name, input int base, input logic [7:0] first, input int len);
    logic [7:0] e;
    check({name, "_len"}, 32'(acc_log.size() - base), 32'(len));
    e = first;
    for (int k = 0; k < len && (base + k) < acc_log.size(); k++) begin
      check({name, "_pc"}, 32'(acc_log[base + k]), 32'(e));
      e++;
    end
  endtask

  initial begin
    int lat;
    int base;
    int n;

    for (int i = 0; i < 256; i++) mem[i] = {OP_ADD, 5'h0A, 8'(i)};
    mem[0]     = {OP_ADD,  13'h0123};
    mem[1]     = {OP_MOVI, 13'h0456};
    mem[2]     = {OP_ADD,  13'h0789};
    mem[3]     = {OP_MOVI, 13'h0ABC};
    mem[4]     = {OP_HALT, 13'h0000};
    mem[8'h12] = {OP_HALT, 13'h0012};
    mem[8'h22] = {OP_HALT, 13'h0022};
    mem[8'h43] = {OP_HALT, 13'h0043};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_rd_en", 32'(imem_rd_en), 32'd0);
    check("rst_word", 32'(instr_word), 32'd0);
    check("rst_pc", 32'(instr_pc), 32'd0);

    // Straight run of the 5-word program with ready held high.
    base = acc_log.size();
    run_start(8'h00, lat);
    check("t1_latency", 32'(lat), 32'd2);
    check("t1_first_pc", 32'(instr_pc), 32'h00);
    wait_halt("t1_halt", 40);
    check_log("t1", base, 8'h00, 5);

    // Restart from HALTED at 0x10.
    base = acc_log.size();
    run_start(8'h10, lat);
    check("t6_latency", 32'(lat), 32'd2);
    check("t6_first_pc", 32'(instr_pc), 32'h10);
    wait_halt("t6_halt", 40);
    check_log("t6", base, 8'h10, 3);

    // Same program under a 1,0,0,1 ready pattern.
    ready_mode = 1;
    base = acc_log.size();
    run_start(8'h00, lat);
    wait_halt("t2_halt", 80);
    check_log("t2", base, 8'h00, 5);
    ready_mode = 0;
    ready_level = 1'b1;
    repeat (2) @(posedge clk);

    // Redirect to 0x40 while the addr-3 fetch is outstanding.
    base = acc_log.size();
    run_start(8'h00, lat);
    n = 0;
    @(negedge clk);
    while (!(imem_rd_en && imem_addr == 8'h03) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t3_saw_issue3", 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc = 8'h40;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    wait_halt("t3_halt", 40);
    check("t3_len", 32'(acc_log.size() - base), 32'd7);
    if (acc_log.size() >= base + 7) begin
      check("t3_pop_in_redirect", 32'(acc_log[base + 2]), 32'h02);
      check("t3_after_redirect", 32'(acc_log[base + 3]), 32'h40);
      check("t3_last", 32'(acc_log[base + 6]), 32'h43);
    end

    // PC wrap from 0xFE.
    base = acc_log.size();
    run_start(8'hFE, lat);
    wait_halt("t4_halt", 40);
    check("t4_len", 32'(acc_log.size() - base), 32'd7);
    if (acc_log.size() >= base + 3) begin
      check("t4_pc0", 32'(acc_log[base]), 32'hFE);
      check("t4_pc1", 32'(acc_log[base + 1]), 32'hFF);
      check("t4_pc2", 32'(acc_log[base + 2]), 32'h00);
    end

    // Reset mid-stream with the queue full, then refetch.
    ready_level = 1'b0;
    repeat (2) @(posedge clk);
    run_start(8'h00, lat);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t5_valid_after_rst", 32'(instr_valid), 32'd0);
    check("t5_halted_after_rst", 32'(halted), 32'd0);
    ready_level = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("t5_still_empty", 32'(instr_valid), 32'd0);
    base = acc_log.size();
    run_start(8'h20, lat);
    check("t5_latency", 32'(lat), 32'd2);
    wait_halt("t5_halt", 40);
    check_log("t5", base, 8'h20, 3);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/module_instr_fetch.md
Name: module_instr_fetch

Overview:
- Instruction fetch/issue unit; the producer side of the opcode interface that the control unit consumes.
- Walks a PC through a synchronous-read instruction memory (1-cycle read latency).
- Buffers returned words in a 2-entry queue and presents them to the decode stage over a valid/ready handshake.
- Supports start, branch redirect with flush of stale fetches, and self-halt on the HALT opcode.

Parameters:
- OPCODE, 3, opcode field width; opcode = instr_word[INSTR_W-1 -: OPCODE].
- INSTR_W, 16, instruction word width.
- ADDR_W, 8, PC / instruction memory address width.
- HALT_OP, 3'b111, opcode value that terminates fetch.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin fetching at start_pc; honoured only in IDLE or HALTED.
- start_pc  in  ADDR_W  first fetch address.
- redirect_valid  in  1  branch redirect; honoured only in RUN.
- redirect_pc  in  ADDR_W  redirect target.
- imem_rd_en  out  1  read strobe (combinational from the issue condition).
- imem_addr  out  ADDR_W  read address, equal to pc.
- imem_rdata  in  INSTR_W  read data, valid the cycle after imem_rd_en.
- instr_valid  out  1  queue head is valid.
- instr_ready  in  1  decode stage accepts.
- instr_word  out  INSTR_W  head word.
- opcode  out  OPCODE  head opcode field.
- instr_pc  out  ADDR_W  address of the head word.
- halted  out  1  high in HALTED.

Behaviour:
- Reset values: state IDLE, pc=0, queue empty, inflight=0, drop=0, instr_valid=0, imem_rd_en=0, halted=0. instr_word, opcode and instr_pc are 0 while empty.
- Reset mid-operation is an immediate return to IDLE; any return data in the following cycle is ignored.
- States and transitions:
  - IDLE: start -> RUN, pc<=start_pc.
  - RUN: fetch and deliver as described below.
  - RUN -> HALTED: the HALT word has been accepted and the queue and in-flight fetch are empty.
  - HALTED: halted=1; start -> RUN, pc<=start_pc.
- Issue rule (RUN, no redirect, halt_seen=0): issue when count + inflight - pop < 2, where pop = instr_valid & instr_ready.
- On issue: imem_rd_en=1, imem_addr=pc, pc<=pc+1 mod 2^ADDR_W (0xFF wraps to 0x00), inflight<=1, and the issued address is recorded.
- Return: the cycle after an issue, imem_rdata and its recorded address are pushed, unless drop=1.
- Simultaneous push and pop with count=1 keeps count=1.
- Latency and throughput:
  - start sampled at edge E0; imem_rd_en=1 with addr=start_pc in the cycle after E0.
  - Word pushed at E2; instr_valid=1 from E2.
  - With instr_ready held high, one word per cycle thereafter.
  - instr_valid never falls while instr_ready=0 (the head is held stable).
- Halt:
  - Pushing a word whose opcode is HALT_OP sets halt_seen; no further issues.
  - A return arriving after the HALT word is discarded.
  - The HALT word itself is delivered to decode.
- Redirect (RUN):
  - Any pop in the same cycle completes normally.
  - Then the queue is flushed, drop<=inflight, halt_seen<=0, and pc<=redirect_pc.
  - No issue in the redirect cycle; the first issue at redirect_pc is in the next cycle.
- Simultaneous start and redirect in IDLE/HALTED: start wins, redirect ignored.
- Redirect while the HALT word is queued: the HALT word is flushed and fetch continues at redirect_pc.

Decomposition:
- Shared package module_isa_defs:
  - Opcode constants OP_ADD=3'b000, OP_MOVI=3'b001, OP_HALT=3'b111.
  - OPCODE, INSTR_W and opcode field position.
  - The same constants the control unit decodes.
- One sub-module, module_fetch_queue: 2-entry FIFO of {addr, word} with push, pop, flush, count and head outputs.
- FSM and PC logic live in the top.

Test Plan:
- Memory 0..4 = {ADD,MOVI,ADD,MOVI,HALT}, start_pc=0, ready=1, start pulsed at E0 -> first valid at E2, then words at pc 0,1,2,3,4 on consecutive cycles; halted=1 after the HALT transfer; no imem_rd_en after addr 5.
- Same program with ready toggled 1,0,0,1,... -> queue never exceeds 2, no word lost or duplicated, and the head is stable while ready=0.
- redirect_valid with redirect_pc=0x40 while a fetch of addr 3 is in flight -> addr-3 data dropped; next delivered instr_pc=0x40; a pop in the redirect cycle is still delivered.
- start_pc=0xFE, straight-line code -> delivered instr_pc sequence 0xFE, 0xFF, 0x00.
- rst asserted for one cycle mid-stream with 2 queued words -> instr_valid=0 next cycle, state IDLE, the following rdata ignored; start then refetches from start_pc.
- In HALTED, start with start_pc=0x10 -> restart; first valid at instr_pc=0x10, two cycles after start.
